// File: rtl/uart_baud_pkg.sv
// Shared types and helpers for the UART baud-rate controller:
// sequencer states, default divisor widths and the saturating reload adder.
package uart_baud_pkg;

   localparam int IBRD_W_DEF = 16;
   localparam int FBRD_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      STOP,
      LOAD
   } state_t;

   // base + inc, clamped to the largest value representable in 'width' bits.
   function automatic logic [31:0] sat_inc(input logic [31:0] base,
                                           input logic        inc,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, base} + 33'(inc);
      lim = (33'd1 << width) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/uart_baud_frac.sv
// Fractional-divisor dither: accumulates the fraction on every 16x tick and
// adds the resulting carry to the integer reload handed to the generator.
module uart_baud_frac
   import uart_baud_pkg::*;
#(
   parameter int IBRD_W = IBRD_W_DEF,
   parameter int FBRD_W = FBRD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic              tick,
   input  logic [IBRD_W-1:0] ibrd,
   input  logic [FBRD_W-1:0] fbrd,
   output logic [IBRD_W-1:0] gen_ibrd
);

   logic [FBRD_W-1:0] acc_q;
   logic              carry_q;
   logic [31:0]       reload;

   // NOTE: state updates use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else if (clear || !enable) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else if (tick) begin
         {carry_q, acc_q} <= {1'b0, acc_q} + {1'b0, fbrd};
      end
   end

   assign reload = sat_inc(32'(ibrd), carry_q, IBRD_W);

   // A zero reload (reset or disabled config with ibrd=0) is floored to 1.
   assign gen_ibrd = (reload == '0) ? IBRD_W'(1) : IBRD_W'(reload);

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud generator configuration sequencer: holds updates until TX/RX are idle,
// then applies them with a one-cycle disable -> load -> enable sequence.
module uart_baud_ctrl
   import uart_baud_pkg::*;
#(
   parameter int IBRD_W = IBRD_W_DEF,
   parameter int FBRD_W = FBRD_W_DEF
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              CfgWr,
   input  logic [IBRD_W-1:0] CfgIBRD,
   input  logic [FBRD_W-1:0] CfgFBRD,
   input  logic              CfgEn,
   output logic              CfgBusy,
   output logic              CfgAck,
   output logic              CfgErr,
   input  logic              TxBusy,
   input  logic              RxBusy,
   input  logic              Baud16,
   output logic [IBRD_W-1:0] GenIBRD,
   output logic [15:0]       GenFBRD,
   output logic              GenEn
);

   state_t            state_q, state_d;
   logic [IBRD_W-1:0] ibrd_q, p_ibrd;
   logic [FBRD_W-1:0] fbrd_q, p_fbrd;
   logic              en_q, p_en;
   logic              err_q;
   logic              cfg_bad, capture, load, err_d;

   // Enabling the generator with a zero divisor is never a legal request.
   assign cfg_bad = CfgEn && (CfgIBRD == '0);

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      load    = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (CfgWr) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  capture = 1'b1;
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            if (CfgWr) begin
               err_d   = cfg_bad;
               capture = !cfg_bad;
            end
            if (!TxBusy && !RxBusy) state_d = STOP;
         end
         STOP: begin
            err_d   = CfgWr;
            state_d = LOAD;
         end
         LOAD: begin
            err_d   = CfgWr;
            load    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         p_ibrd  <= '0;
         p_fbrd  <= '0;
         p_en    <= 1'b0;
         ibrd_q  <= '0;
         fbrd_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (capture) begin
            p_ibrd <= CfgIBRD;
            p_fbrd <= CfgFBRD;
            p_en   <= CfgEn;
         end
         if (load) begin
            ibrd_q <= p_ibrd;
            fbrd_q <= p_fbrd;
            en_q   <= p_en;
         end
      end
   end

   assign CfgBusy = (state_q != IDLE);
   assign CfgAck  = (state_q == LOAD);
   assign CfgErr  = err_q;
   assign GenFBRD = '0;
   // The single STOP cycle forces the generator counter back to its reload state.
   assign GenEn   = en_q && (state_q != STOP);

   uart_baud_frac #(
      .IBRD_W(IBRD_W),
      .FBRD_W(FBRD_W)
   ) u_frac (
      .clk     (CLK),
      .rst_n   (RESETn),
      .clear   (load),
      .enable  (GenEn),
      .tick    (Baud16),
      .ibrd    (ibrd_q),
      .fbrd    (fbrd_q),
      .gen_ibrd(GenIBRD)
   );

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Configuration sequencer and fractional-divisor controller for the UART baud-rate generator. Sits between the UART register file and the generator instance. Applies divisor/enable updates only when the TX and RX datapaths are idle, using a disable→load→enable sequence. Dithers the generator's integer reload value on a per-period basis to realise a 6-bit fractional divisor.

## Interface
Parameters:
- IBRD_W, 16, integer divisor width; matches generator IBRD port.
- FBRD_W, 6, fractional divisor width; fraction unit is 1/2^FBRD_W.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- CLK  in  1  system clock.
- RESETn  in  1  synchronous active-low reset.
- CfgWr  in  1  one-cycle configuration write request.
- CfgIBRD  in  IBRD_W  requested integer divisor.
- CfgFBRD  in  FBRD_W  requested fractional divisor.
- CfgEn  in  1  requested generator enable.
- CfgBusy  out  1  a configuration is pending or being applied.
- CfgAck  out  1  one-cycle pulse: configuration applied.
- CfgErr  out  1  one-cycle pulse: write rejected or dropped.
- TxBusy  in  1  transmitter mid-frame.
- RxBusy  in  1  receiver mid-frame.
- Baud16  in  1  16x tick from generator.
- GenIBRD  out  16  reload value to generator.
- GenFBRD  out  16  generator FBRD port; constant 0, because the fraction is handled here.
- GenEn  out  1  generator enable.

## Operation
Shadow registers:
- ibrd_q, fbrd_q, en_q hold the active configuration.
- p_ibrd, p_fbrd, p_en hold the pending configuration.

FSM states:
- IDLE: no update in progress. The generator runs according to en_q.
  - CfgWr with CfgEn=1 and CfgIBRD=0: rejected. CfgErr pulses; no state change.
  - Any other CfgWr: captured into p_*, CfgBusy set, next state PEND.
- PEND: wait for TxBusy=0 and RxBusy=0 in the same cycle, then go to STOP.
  - CfgWr in PEND: valid values overwrite p_* (latest wins; a single ack is issued).
  - Invalid values (CfgEn=1, CfgIBRD=0): CfgErr pulses and p_* is kept.
- STOP: GenEn=0 for exactly one cycle, which forces the generator counter to its reload state. Next state LOAD.
- LOAD:
  - Copy p_* into the active shadows.
  - Clear the fraction accumulator and the carry.
  - GenEn takes p_en from the next cycle.
  - CfgAck pulses; CfgBusy clears; next state IDLE.
- CfgWr in STOP or LOAD is dropped and CfgErr pulses.

Fraction accumulator (acc, FBRD_W bits):
- On each cycle with Baud16=1 and GenEn=1: {carry_q, acc} <= acc + fbrd_q.
- GenIBRD = ibrd_q + carry_q. It saturates at 2^IBRD_W−1 if ibrd_q is all-ones and carry_q=1.
- Long-run mean period = ibrd_q + fbrd_q/2^FBRD_W clocks.
- fbrd_q=0 gives GenIBRD = ibrd_q constantly.

While GenEn=0, acc and carry_q hold at 0.

Reset values:
- Outputs: GenEn=0, GenIBRD=16'd1, GenFBRD=0, CfgBusy=0, CfgAck=0, CfgErr=0.
- Internal: state IDLE, acc=0, carry_q=0, all shadows 0.

## Timing
- CfgWr is sampled at the edge. CfgBusy is high from the cycle after acceptance.
- Idle path, minimum latency:
  - Write at edge N with datapaths idle.
  - PEND at N+1, STOP at N+2 (GenEn=0 during N+2..N+3), LOAD at N+3.
  - CfgAck high in cycle N+3..N+4; new GenIBRD/GenEn valid from N+4.
- Busy path: PEND is held indefinitely while either busy input is high. There is no timeout.
- Baud16-to-GenIBRD: carry_q updates one cycle after the Baud16 pulse. It therefore affects the generator reload after next, which is acceptable because only the mean period matters.
- Baud16 arriving in STOP or LOAD is ignored.
- Synchronous reset mid-sequence returns to IDLE and discards the pending configuration; no ack is issued.

## Structure
- Package uart_baud_pkg holds:
  - the state enum (IDLE, PEND, STOP, LOAD);
  - the IBRD_W/FBRD_W defaults;
  - the saturating-add helper.
- Sub-module uart_baud_frac holds the accumulator, carry, saturating GenIBRD adder, and clear/enable inputs. The FSM stays in uart_baud_ctrl.

## Test plan
- Reset, then write IBRD=10, FBRD=0, En=1 with idle datapaths → CfgAck 3 cycles after the write; GenEn=1, GenIBRD=10; Baud16 period 10 clocks.
- IBRD=10, FBRD=32 → GenIBRD alternates 10/11 on successive Baud16 ticks; mean period 10.5 over 64 ticks.
- TxBusy=1 at write time, deasserted 50 cycles later → no GenEn change until 2 cycles after TxBusy falls; CfgBusy high throughout.
- Write En=1 with IBRD=0 in IDLE → CfgErr pulse, CfgBusy stays 0, outputs unchanged.
- Two writes in PEND (IBRD=20, then IBRD=30) → single CfgAck; GenIBRD=30.
- RESETn low during STOP → GenEn=0, GenIBRD=1, no CfgAck, state IDLE.
